// File: rtl/nmi_multicore_arb.sv
// Round-robin arbiter sharing one NMI master port among NUM_CORE cores.
// One transaction in flight; hung-slave timeout answers with ERR_DATA and sets a sticky error.
module nmi_multicore_arb #(
    parameter int NUM_CORE = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 1023,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF),
    localparam int GW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1,
    localparam int SW = DATA_W / 8,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CORE-1:0]        core_en_i,
    input  logic [NUM_CORE-1:0]        core_valid_i,
    input  logic [NUM_CORE*ADDR_W-1:0] core_addr_i,
    input  logic [NUM_CORE*DATA_W-1:0] core_wdata_i,
    input  logic [NUM_CORE*SW-1:0]     core_wstrb_i,
    output logic [NUM_CORE-1:0]        core_ready_o,
    output logic [DATA_W-1:0]          core_rdata_o,
    output logic                       mst_valid_o,
    output logic [ADDR_W-1:0]          mst_addr_o,
    output logic [DATA_W-1:0]          mst_wdata_o,
    output logic [SW-1:0]              mst_wstrb_o,
    input  logic                       mst_ready_i,
    input  logic [DATA_W-1:0]          mst_rdata_i,
    output logic [GW-1:0]              grant_o,
    output logic                       busy_o,
    output logic                       err_o,
    input  logic                       err_clr_i
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [GW-1:0]       r_ptr;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       w_sel;
    logic [GW-1:0]       w_ptr_nxt;
    logic                w_found;
    logic [NUM_CORE-1:0] w_req;
    logic [CW-1:0]       r_cnt;
    logic                w_timeout;
    logic                w_done;
    logic                w_abort;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [SW-1:0]       r_wstrb;
    logic                r_err;

    assign w_req     = core_valid_i & core_en_i;
    assign w_timeout = (r_cnt == CW'(TIMEOUT));
    assign w_ptr_nxt = (r_grant == GW'(NUM_CORE - 1)) ? '0 : r_grant + 1'b1;

    // First requesting core at or after r_ptr, wrapping around.
    always_comb begin
        int k;
        k       = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_CORE; i++) begin
            k = (int'(r_ptr) + i) % NUM_CORE;
            if (!w_found && w_req[k]) begin
                w_found = 1'b1;
                w_sel   = GW'(k);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        core_ready_o = '0;
        core_rdata_o = '0;
        case (r_state)
            S_IDLE: if (w_found) w_next = S_BUSY;
            S_BUSY: begin
                // A ready arriving in the timeout cycle still counts as success.
                if (mst_ready_i) begin
                    w_done       = 1'b1;
                    core_rdata_o = mst_rdata_i;
                end else if (w_timeout) begin
                    w_done       = 1'b1;
                    w_abort      = 1'b1;
                    core_rdata_o = ERR_DATA;
                end
                if (w_done) begin
                    w_next                = S_IDLE;
                    core_ready_o[r_grant] = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (rst_i) begin
            w_done       = 1'b0;
            w_abort      = 1'b0;
            core_ready_o = '0;
            core_rdata_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_grant <= w_sel;
                r_addr  <= core_addr_i[w_sel*ADDR_W +: ADDR_W];
                r_wdata <= core_wdata_i[w_sel*DATA_W +: DATA_W];
                r_wstrb <= core_wstrb_i[w_sel*SW +: SW];
                r_cnt   <= '0;
            end
            if (r_state == S_BUSY) begin
                if (w_done) begin
                    r_cnt <= '0;
                    r_ptr <= w_ptr_nxt;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_abort)        r_err <= 1'b1;
            else if (err_clr_i) r_err <= 1'b0;
        end
    end

    assign mst_valid_o = (r_state == S_BUSY);
    assign busy_o      = (r_state == S_BUSY);
    assign mst_addr_o  = r_addr;
    assign mst_wdata_o = r_wdata;
    assign mst_wstrb_o = r_wstrb;
    assign grant_o     = r_grant;
    assign err_o       = r_err;

endmodule

// File: tb/tb_nmi_multicore_arb.sv
// Directed bench for nmi_multicore_arb: single read, fairness, enable mask,
// timeout and tie, write latching, reset mid-transaction.
module tb_nmi_multicore_arb;

    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] core_en;
    logic [NC-1:0] core_valid;
    logic [NC*32-1:0] core_addr;
    logic [NC*32-1:0] core_wdata;
    logic [NC*4-1:0]  core_wstrb;
    logic [NC-1:0] core_ready;
    logic [31:0]   core_rdata;
    logic          mst_valid;
    logic [31:0]   mst_addr;
    logic [31:0]   mst_wdata;
    logic [3:0]    mst_wstrb;
    logic          mst_ready;
    logic [31:0]   mst_rdata;
    logic [1:0]    grant;
    logic          busy;
    logic          err;
    logic          err_clr;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_g;

    nmi_multicore_arb #(.NUM_CORE(NC), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_en_i(core_en), .core_valid_i(core_valid),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_wstrb_i(core_wstrb),
        .core_ready_o(core_ready), .core_rdata_o(core_rdata),
        .mst_valid_o(mst_valid), .mst_addr_o(mst_addr), .mst_wdata_o(mst_wdata),
        .mst_wstrb_o(mst_wstrb), .mst_ready_i(mst_ready), .mst_rdata_i(mst_rdata),
        .grant_o(grant), .busy_o(busy), .err_o(err), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; core_en = 4'hF; core_valid = '0; core_addr = '0;
        core_wdata = '0; core_wstrb = '0; mst_ready = 1'b0; mst_rdata = '0; err_clr = 1'b0;
        repeat (2) tick();
        check("rst_mst_valid", mst_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_err", err, 0);
        check("rst_core_ready", core_ready, 0);
        check("rst_core_rdata", core_rdata, 0);
        check("rst_mst_addr", mst_addr, 0);
        rst = 1'b0;

        // single read from core 0
        core_valid = 4'b0001; core_addr[0 +: 32] = 32'h3000_0000; core_wstrb[0 +: 4] = 4'h0;
        #1;
        check("t1_valid_not_yet", mst_valid, 0);
        tick();
        check("t1_mst_valid", mst_valid, 1);
        check("t1_mst_addr", mst_addr, 32'h3000_0000);
        check("t1_mst_wstrb", mst_wstrb, 0);
        check("t1_grant", grant, 0);
        check("t1_no_ready", core_ready, 0);
        tick();
        tick();
        check("t1_still_busy", busy, 1);
        mst_ready = 1'b1; mst_rdata = 32'h1234_5678;
        #1;
        check("t1_core_ready", core_ready, 4'b0001);
        check("t1_core_rdata", core_rdata, 32'h1234_5678);
        tick();
        mst_ready = 1'b0; core_valid = '0;
        #1;
        check("t1_valid_drop", mst_valid, 0);
        check("t1_ready_drop", core_ready, 0);
        check("t1_rdata_zero", core_rdata, 0);

        // fairness: reset the pointer, then all cores request continuously
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NC; i++) core_addr[i*32 +: 32] = 32'h4000_0000 + 32'(i * 4);
        core_valid = 4'b1111;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        while (exp_q.size() > 0) begin
            exp_g = exp_q.pop_front();
            tick();
            check("t2_grant", grant, exp_g);
            check("t2_addr", mst_addr, 32'h4000_0000 + 32'(exp_g) * 4);
            mst_ready = 1'b1; mst_rdata = 32'hA000_0000 | 32'(exp_g);
            #1;
            check("t2_core_ready", core_ready, 4'b0001 << exp_g);
            check("t2_core_rdata", core_rdata, 32'hA000_0000 | 32'(exp_g));
            tick();
            mst_ready = 1'b0;
        end

        // enable mask: only cores 1 and 3, pointer currently at 1
        core_en = 4'b1010;
        exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        while (exp_q.size() > 0) begin
            exp_g = exp_q.pop_front();
            tick();
            check("t3_grant", grant, exp_g);
            mst_ready = 1'b1;
            #1;
            check("t3_core_ready", core_ready, 4'b0001 << exp_g);
            tick();
            mst_ready = 1'b0;
        end
        core_valid = '0; core_en = 4'hF;

        // timeout: slave never answers core 1
        core_valid = 4'b0010;
        tick();
        check("t4_grant", grant, 1);
        for (int i = 0; i < 8; i++) begin
            check("t4_no_early_ready", core_ready, 0);
            tick();
        end
        check("t4_abort_ready", core_ready, 4'b0010);
        check("t4_abort_rdata", core_rdata, 32'hDEAD_BEEF);
        check("t4_err_not_yet", err, 0);
        tick();
        core_valid = '0;
        check("t4_err_set", err, 1);
        check("t4_idle", busy, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t4_err_clr", err, 0);

        // ready arriving in the timeout cycle wins
        core_valid = 4'b0010;
        tick();
        check("t4b_grant", grant, 1);
        repeat (8) tick();
        mst_ready = 1'b1; mst_rdata = 32'h55AA_33CC;
        #1;
        check("t4b_ready", core_ready, 4'b0010);
        check("t4b_rdata", core_rdata, 32'h55AA_33CC);
        tick();
        mst_ready = 1'b0; core_valid = '0;
        check("t4b_no_err", err, 0);

        // write from core 2; core changes its inputs and drops valid mid-transaction
        core_addr[64 +: 32] = 32'h1000_0010; core_wdata[64 +: 32] = 32'hCAFE_F00D;
        core_wstrb[8 +: 4] = 4'b0011; core_valid = 4'b0100;
        tick();
        check("t5_grant", grant, 2);
        check("t5_addr", mst_addr, 32'h1000_0010);
        check("t5_wdata", mst_wdata, 32'hCAFE_F00D);
        check("t5_wstrb", mst_wstrb, 4'b0011);
        core_valid = '0; core_addr[64 +: 32] = '0; core_wdata[64 +: 32] = '0; core_wstrb[8 +: 4] = '0;
        tick();
        check("t5_hold_valid", mst_valid, 1);
        check("t5_hold_addr", mst_addr, 32'h1000_0010);
        check("t5_hold_wdata", mst_wdata, 32'hCAFE_F00D);
        check("t5_hold_wstrb", mst_wstrb, 4'b0011);
        mst_ready = 1'b1; mst_rdata = '0;
        #1;
        check("t5_ready", core_ready, 4'b0100);
        tick();
        mst_ready = 1'b0;

        // reset while busy with core 2
        core_valid = 4'b0100;
        tick();
        check("t6_grant", grant, 2);
        rst = 1'b1; mst_ready = 1'b1;
        #1;
        check("t6_no_ready_in_rst", core_ready, 0);
        tick();
        mst_ready = 1'b0; rst = 1'b0;
        check("t6_valid_drop", mst_valid, 0);
        check("t6_busy_drop", busy, 0);
        check("t6_grant_rst", grant, 0);
        core_valid = 4'b1111;
        tick();
        check("t6_ptr_restart", grant, 0);
        mst_ready = 1'b1;
        #1;
        check("t6_ready", core_ready, 4'b0001);
        tick();
        mst_ready = 1'b0; core_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
